// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter
// Description : Round-robin front end that shares one multi-cycle divider
//               among NUM_REQ requesters, with divide-by-zero bypass and a
//               watchdog that aborts and resets a hung divider.
// Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter #(
    parameter int N       = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_dividend,
    input  logic [NUM_REQ*N-1:0] req_divisor,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [N-1:0]         resp_result,
    output logic                 resp_div0,
    output logic                 resp_err,
    output logic                 div_start,
    output logic [N-1:0]         div_dividend,
    output logic [N-1:0]         div_divisor,
    output logic                 div_reset,
    input  logic [N-1:0]         div_result,
    input  logic                 div_done
);

    localparam int c_IDX_W  = $clog2(NUM_REQ);
    localparam int c_SCAN_W = c_IDX_W + 1;
    localparam int c_WD_W   = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    localparam logic [NUM_REQ-1:0] c_ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [c_IDX_W-1:0]  r_gnt;
    logic [c_IDX_W-1:0]  w_gnt_idx;
    logic [NUM_REQ-1:0]  w_grant;
    logic [c_SCAN_W-1:0] w_scan;
    logic                w_found;
    logic                w_accept;
    logic                w_div0_req;
    logic                w_timeout;
    logic                w_wd_warn;
    logic [N-1:0]        w_dvd [NUM_REQ];
    logic [N-1:0]        w_dvs [NUM_REQ];
    logic [N-1:0]        r_div_dividend;
    logic [N-1:0]        r_div_divisor;
    logic [N-1:0]        r_resp_result;
    logic                r_resp_div0;
    logic                r_resp_err;
    logic                r_div_reset;
    logic [c_WD_W-1:0]   r_wdog;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_dvd[i] = req_dividend[i*N +: N];
        assign w_dvs[i] = req_divisor[i*N +: N];
    end

    // Scan starts one past the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        w_scan    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + c_SCAN_W'(k);
            if (w_scan >= c_SCAN_W'(NUM_REQ)) begin
                w_scan = w_scan - c_SCAN_W'(NUM_REQ);
            end
            if (!w_found && req_valid[w_scan[c_IDX_W-1:0]]) begin
                w_found                       = 1'b1;
                w_gnt_idx                     = w_scan[c_IDX_W-1:0];
                w_grant[w_scan[c_IDX_W-1:0]] = 1'b1;
            end
        end
    end

    assign w_accept   = (r_state == c_ST_IDLE) && w_found;
    assign w_div0_req = (w_dvs[w_gnt_idx] == '0);
    assign w_timeout  = (r_wdog == c_WD_W'(TIMEOUT - 1));
    // Raising div_reset one cycle early lines it up with the abort cycle.
    assign w_wd_warn  = (r_wdog == c_WD_W'(TIMEOUT - 2));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_div0_req ? c_ST_RESP : c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: w_state_next = c_ST_WAIT;
            c_ST_WAIT: begin
                if (div_done || w_timeout) begin
                    w_state_next = c_ST_RESP;
                end
            end
            c_ST_RESP: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        div_start  = 1'b0;
        case (r_state)
            c_ST_IDLE:  req_ready  = w_grant;
            c_ST_ISSUE: div_start  = 1'b1;
            c_ST_RESP:  resp_valid = c_ONE_HOT0 << r_gnt;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr       <= c_IDX_W'(NUM_REQ - 1);
            r_gnt          <= '0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_resp_result  <= '0;
            r_resp_div0    <= 1'b0;
            r_resp_err     <= 1'b0;
            r_div_reset    <= 1'b1;
            r_wdog         <= '0;
        end else begin
            r_div_reset <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_gnt    <= w_gnt_idx;
                        r_rr_ptr <= w_gnt_idx;
                        if (w_div0_req) begin
                            r_resp_result <= '1;
                            r_resp_div0   <= 1'b1;
                        end else begin
                            r_div_dividend <= w_dvd[w_gnt_idx];
                            r_div_divisor  <= w_dvs[w_gnt_idx];
                        end
                    end
                end
                c_ST_ISSUE: r_wdog <= '0;
                c_ST_WAIT: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (div_done) begin
                        r_resp_result <= div_result;
                    end else if (w_timeout) begin
                        r_resp_result <= '0;
                        r_resp_err    <= 1'b1;
                    end else if (w_wd_warn) begin
                        r_div_reset <= 1'b1;
                    end
                end
                c_ST_RESP: begin
                    r_resp_result <= '0;
                    r_resp_div0   <= 1'b0;
                    r_resp_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign div_dividend = r_div_dividend;
    assign div_divisor  = r_div_divisor;
    assign div_reset    = r_div_reset;
    assign resp_result  = r_resp_result;
    assign resp_div0    = r_resp_div0;
    assign resp_err     = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_arbiter
// Description : Self-checking bench for div_arbiter with a behavioural divider
//               and a cycle-level transaction model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

    localparam int N  = 8;
    localparam int NR = 4;
    localparam int TO = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*N-1:0] req_dividend = '0;
    logic [NR*N-1:0] req_divisor = '0;
    logic [NR-1:0]   resp_valid;
    logic [N-1:0]    resp_result;
    logic            resp_div0;
    logic            resp_err;
    logic            div_start;
    logic [N-1:0]    div_dividend;
    logic [N-1:0]    div_divisor;
    logic            div_reset;
    logic [N-1:0]    div_result;
    logic            div_done = 1'b0;

    div_arbiter #(.N(N), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .resp_valid(resp_valid), .resp_result(resp_result),
        .resp_div0(resp_div0), .resp_err(resp_err),
        .div_start(div_start), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_reset(div_reset),
        .div_result(div_result), .div_done(div_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider: N busy cycles after start, then a 1-cycle done.
    logic [N-1:0] dv_q = '0;
    logic         dv_busy = 1'b0;
    int           dv_cnt = 0;
    bit           hang = 1'b0;
    assign div_result = dv_q;

    always @(posedge clk) begin
        if (div_reset) begin
            dv_busy  <= 1'b0;
            div_done <= 1'b0;
            dv_cnt   <= 0;
        end else if (div_done) begin
            div_done <= 1'b0;
        end else if (dv_busy) begin
            if (dv_cnt == 1) begin
                if (!hang) begin
                    dv_busy  <= 1'b0;
                    div_done <= 1'b1;
                end
            end else begin
                dv_cnt <= dv_cnt - 1;
            end
        end else if (div_start) begin
            dv_busy <= 1'b1;
            dv_cnt  <= N;
            dv_q    <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Requester-side stimulus state
    logic [N-1:0]  tb_dvd [NR];
    logic [N-1:0]  tb_dvs [NR];
    logic [NR-1:0] raise_mask = '0;
    logic [NR-1:0] acc_mask = '0;

    // Transaction model: one operation in flight, timing from the latency rules
    int           m_last, m_free, m_resp_cyc, m_start_cyc, m_drst_cyc, m_idx;
    bit           m_pend, m_div0, m_err;
    logic [N-1:0] m_res, m_dvd, m_dvs;
    int           last_acc = 0;
    int           n_starts = 0;

    int           obs_idx [$];
    int           obs_cyc [$];
    logic [N-1:0] obs_res [$];
    bit           obs_div0 [$];
    bit           obs_err [$];

    task automatic model_reset();
        m_last      = NR - 1;
        m_free      = 0;
        m_pend      = 1'b0;
        m_resp_cyc  = -1;
        m_start_cyc = -1;
        m_drst_cyc  = -1;
    endtask

    task automatic pack();
        for (int i = 0; i < NR; i++) begin
            req_dividend[i*N +: N] = tb_dvd[i];
            req_divisor[i*N +: N]  = tb_dvs[i];
        end
    endtask

    task automatic step(input bit rnd);
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_rv;
        int            g;
        int            c;
        int            j;
        @(negedge clk);
        req_valid  = (req_valid & ~acc_mask) | raise_mask;
        acc_mask   = '0;
        raise_mask = '0;
        if (rnd) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    tb_dvd[i]    = 8'($urandom_range(255));
                    tb_dvs[i]    = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(255));
                    req_valid[i] = 1'b1;
                end
            end
        end
        pack();
        #1;
        c = cyc;
        exp_ready = '0;
        g = -1;
        if (c >= m_free) begin
            for (int k = 1; k <= NR; k++) begin
                j = (m_last + k) % NR;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        exp_rv = '0;
        if (m_pend && c == m_resp_cyc) exp_rv[m_idx] = 1'b1;
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("resp_result", 32'(resp_result), (exp_rv != 0) ? 32'(m_res) : 32'd0);
        chk("resp_div0", 32'(resp_div0), (exp_rv != 0) ? 32'(m_div0) : 32'd0);
        chk("resp_err", 32'(resp_err), (exp_rv != 0) ? 32'(m_err) : 32'd0);
        chk("div_start", 32'(div_start), 32'(m_pend && c == m_start_cyc));
        if (m_pend && c == m_start_cyc) begin
            chk("div_dividend", 32'(div_dividend), 32'(m_dvd));
            chk("div_divisor", 32'(div_divisor), 32'(m_dvs));
        end
        chk("div_reset", 32'(div_reset), 32'(m_pend && c == m_drst_cyc));
        if (div_start) n_starts++;
        if (resp_valid != 0) begin
            for (int i = 0; i < NR; i++) if (resp_valid[i]) obs_idx.push_back(i);
            obs_res.push_back(resp_result);
            obs_cyc.push_back(c);
            obs_div0.push_back(resp_div0);
            obs_err.push_back(resp_err);
        end
        if (exp_rv != 0) m_pend = 1'b0;
        if (g >= 0) begin
            m_last      = g;
            acc_mask[g] = 1'b1;
            last_acc    = c;
            m_pend      = 1'b1;
            m_idx       = g;
            m_dvd       = tb_dvd[g];
            m_dvs       = tb_dvs[g];
            m_drst_cyc  = -1;
            m_err       = 1'b0;
            m_div0      = 1'b0;
            if (m_dvs == 0) begin
                m_res       = '1;
                m_div0      = 1'b1;
                m_start_cyc = -1;
                m_resp_cyc  = c + 1;
                m_free      = c + 2;
            end else if (hang) begin
                m_res       = '0;
                m_err       = 1'b1;
                m_start_cyc = c + 1;
                m_drst_cyc  = c + TO + 1;
                m_resp_cyc  = c + TO + 2;
                m_free      = c + TO + 3;
            end else begin
                m_res       = m_dvd / m_dvs;
                m_start_cyc = c + 1;
                m_resp_cyc  = c + N + 3;
                m_free      = c + N + 4;
            end
        end
    endtask

    typedef struct {
        int           idx;
        logic [N-1:0] dvd;
        logic [N-1:0] dvs;
        logic [N-1:0] res;
        bit           div0;
        bit           err;
        bit           hang;
        int           lat;
    } vec_t;

    vec_t vecs [7];

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int exp_vals  [5] = '{4, 6, 8, 10, 4};

    initial begin
        int n0;
        int s0;
        bit re0;

        vecs[0] = '{0, 8'd100, 8'd7,   8'd14,  1'b0, 1'b0, 1'b0, N + 3};
        vecs[1] = '{1, 8'd9,   8'd0,   8'hFF,  1'b1, 1'b0, 1'b0, 1};
        vecs[2] = '{2, 8'd255, 8'd1,   8'd255, 1'b0, 1'b0, 1'b0, N + 3};
        vecs[3] = '{3, 8'd5,   8'd9,   8'd0,   1'b0, 1'b0, 1'b0, N + 3};
        vecs[4] = '{0, 8'd255, 8'd255, 8'd1,   1'b0, 1'b0, 1'b0, N + 3};
        vecs[5] = '{0, 8'd77,  8'd7,   8'd0,   1'b0, 1'b1, 1'b1, TO + 2};
        vecs[6] = '{1, 8'd12,  8'd4,   8'd3,   1'b0, 1'b0, 1'b0, N + 3};
        for (int i = 0; i < NR; i++) begin
            tb_dvd[i] = '0;
            tb_dvs[i] = '0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_result", 32'(resp_result), 32'd0);
        chk("rst_flags", 32'({resp_div0, resp_err, div_start}), 32'd0);
        chk("rst_div_operands", 32'({div_dividend, div_divisor}), 32'd0);
        chk("rst_div_reset", 32'(div_reset), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // All four requesters at once, then req0 comes back behind req2/req3
        for (int i = 0; i < NR; i++) begin
            tb_dvd[i] = 8'(20 + 10 * i);
            tb_dvs[i] = 8'd5;
        end
        raise_mask = '1;
        obs_idx.delete(); obs_res.delete(); obs_cyc.delete(); obs_div0.delete(); obs_err.delete();
        re0 = 1'b0;
        for (int t = 0; t < 120 && obs_idx.size() < 5; t++) begin
            step(1'b0);
            if (obs_idx.size() == 1 && !re0) begin
                tb_dvd[0]     = 8'd20;
                raise_mask[0] = 1'b1;
                re0           = 1'b1;
            end
        end
        chk("rr_resp_count", 32'(obs_idx.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs_idx.size(); i++) begin
            chk("rr_order", 32'(obs_idx[i]), 32'(exp_order[i]));
            chk("rr_result", 32'(obs_res[i]), 32'(exp_vals[i]));
        end

        // Directed single-request vectors
        foreach (vecs[v]) begin
            hang = vecs[v].hang;
            tb_dvd[vecs[v].idx] = vecs[v].dvd;
            tb_dvs[vecs[v].idx] = vecs[v].dvs;
            raise_mask[vecs[v].idx] = 1'b1;
            n0 = obs_idx.size();
            s0 = n_starts;
            for (int t = 0; t < 80 && obs_idx.size() == n0; t++) step(1'b0);
            chk("vec_response_seen", 32'(obs_idx.size()), 32'(n0 + 1));
            if (obs_idx.size() > n0) begin
                chk("vec_index", 32'(obs_idx[n0]), 32'(vecs[v].idx));
                chk("vec_result", 32'(obs_res[n0]), 32'(vecs[v].res));
                chk("vec_div0", 32'(obs_div0[n0]), 32'(vecs[v].div0));
                chk("vec_err", 32'(obs_err[n0]), 32'(vecs[v].err));
                chk("vec_latency", 32'(obs_cyc[n0] - last_acc), 32'(vecs[v].lat));
                chk("vec_start_count", 32'(n_starts - s0), vecs[v].div0 ? 32'd0 : 32'd1);
            end
            step(1'b0);
            step(1'b0);
        end
        hang = 1'b0;

        // Reset while the divider is busy
        tb_dvd[1] = 8'd100;
        tb_dvs[1] = 8'd7;
        raise_mask[1] = 1'b1;
        s0 = 0;
        for (int t = 0; t < 30 && !(m_pend && cyc >= last_acc + 5); t++) step(1'b0);
        chk("abort_in_flight", 32'(m_pend), 32'd1);
        @(negedge clk);
        reset      = 1'b0;
        req_valid  = '0;
        acc_mask   = '0;
        raise_mask = '0;
        @(posedge clk);
        #1;
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_result", 32'(resp_result), 32'd0);
        chk("abort_flags", 32'({resp_div0, resp_err, div_start}), 32'd0);
        chk("abort_div_operands", 32'({div_dividend, div_divisor}), 32'd0);
        chk("abort_div_reset", 32'(div_reset), 32'd1);
        @(posedge clk);
        #1;
        chk("abort_div_reset_held", 32'(div_reset), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        n0 = obs_idx.size();
        repeat (20) step(1'b0);
        chk("abort_no_response", 32'(obs_idx.size()), 32'(n0));
        tb_dvd[0] = 8'd100; tb_dvs[0] = 8'd7;
        tb_dvd[2] = 8'd50;  tb_dvs[2] = 8'd5;
        raise_mask = 4'b0101;
        for (int t = 0; t < 60 && obs_idx.size() < n0 + 2; t++) step(1'b0);
        chk("post_reset_count", 32'(obs_idx.size()), 32'(n0 + 2));
        if (obs_idx.size() >= n0 + 2) begin
            chk("post_reset_first", 32'(obs_idx[n0]), 32'd0);
            chk("post_reset_result", 32'(obs_res[n0]), 32'd14);
            chk("post_reset_second", 32'(obs_idx[n0+1]), 32'd2);
        end

        // Random traffic against the model, then drain
        repeat (400) step(1'b1);
        for (int t = 0; t < 400 && (req_valid != 0 || m_pend); t++) step(1'b0);
        chk("drain", 32'(req_valid != 0 || m_pend), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one multi-cycle `divider` (non-restoring, N-bit unsigned quotient, start/done handshake) among NUM_REQ requesters, e.g. per-thread ALUs in a core.
- Round-robin grant; one division in flight at a time.
- Sequences divider start, waits for done, and returns the quotient to the granted requester.
- Bypasses divide-by-zero and recovers a hung divider with a watchdog.

Parameters:
N, 8, operand/result width; must match the attached divider's N
NUM_REQ, 4, number of requesters (>=2)
TIMEOUT, 32, max cycles spent in WAIT before abort (>= N+2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  request pending; held with operands stable until accepted
req_ready  out  NUM_REQ  one-hot accept, combinational
req_dividend  in  NUM_REQ*N  packed dividends, requester i at [i*N +: N]
req_divisor  in  NUM_REQ*N  packed divisors, same packing
resp_valid  out  NUM_REQ  one-hot, 1-cycle response pulse
resp_result  out  N  quotient; valid while any resp_valid bit is high
resp_div0  out  1  response was a divide-by-zero bypass
resp_err  out  1  response was a watchdog abort
div_start  out  1  to divider start
div_dividend  out  N  to divider dividend (registered)
div_divisor  out  N  to divider divisor (registered)
div_reset  out  1  to divider reset (active-high, registered)
div_result  in  N  from divider result
div_done  in  1  from divider done

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has top priority.
  - resp_valid, resp_div0, resp_err, div_start, div_dividend, div_divisor and resp_result all 0.
  - div_reset=1, and stays 1 on every edge while reset==0.
  - Reset aborts any in-flight operation; no response is produced for it.
- Grant:
  - Only in IDLE, scan from rr_ptr+1 (mod NUM_REQ) upward; the first i with req_valid[i]=1 gets req_ready[i]=1.
  - req_ready is 0 outside IDLE.
  - Accept = valid&ready at an edge. On accept, latch the index as gnt and set rr_ptr=gnt.
- States:
  - IDLE:
    - No valid request: stay in IDLE.
    - Accept with divisor==0: go to RESP; result=all-ones, div0=1; no div_start.
    - Accept with divisor!=0: latch operands into div_dividend/div_divisor, go to ISSUE.
  - ISSUE: div_start=1 for exactly this cycle; clear the watchdog; go to WAIT.
  - WAIT:
    - div_start=0; watchdog increments each cycle.
    - On div_done=1: capture div_result into resp_result, go to RESP.
    - If the watchdog reaches TIMEOUT without done: resp_result=0, err=1, div_reset=1 for one cycle, go to RESP.
    - If done and timeout coincide, done wins.
  - RESP: resp_valid[gnt]=1 with resp_div0/resp_err; next state IDLE. All resp_* outputs clear the following cycle.
- Latency (accept edge at cycle a, nominal divider: RUN for N cycles, done high for 1 cycle):
  - ISSUE at a+1.
  - Divider done seen at a+N+2.
  - RESP at a+N+3 (a+11 for N=8).
  - IDLE at a+N+4, when the next accept is possible. The divider is back in IDLE by then.
  - Divide-by-zero: RESP at a+1.
- div_done seen outside WAIT is ignored.
- Requesters may deassert req_valid only after acceptance. Changing operands while valid && !ready is a protocol violation; the design may assert on it.
- Width rules:
  - Quotient is unsigned, N bits, floor(dividend/divisor).
  - Packed-bus slicing uses i*N; no sign extension.

Test Plan:
1. N=8. Req0: 100/7, accepted at cycle a -> div_start pulse at a+1; resp_valid=4'b0001 at a+11 with resp_result=14, div0=0, err=0.
2. After reset, all four valid simultaneously (dividends 20,30,40,50; divisor 5) -> grants in order 0,1,2,3 with results 4,6,8,10. Req0 then re-requests while req2 is still pending -> req2 is served before req0.
3. Req1: 9/0 -> resp_valid=4'b0010 at a+1, resp_result=8'hFF, resp_div0=1; div_start never asserted.
4. Boundaries: 255/1 -> 255; 5/9 -> 0; 255/255 -> 1. Each result arrives exactly N+3 cycles after accept.
5. Divider model holds div_done=0, TIMEOUT=32 -> resp_err=1, resp_result=0 at a+34; div_reset high for 1 cycle at a+33. A following 12/4 request returns 3 normally.
6. Drive reset low during WAIT -> all outputs at reset values next edge and div_reset=1; no resp_valid for the aborted request. After release, req0 has top priority and 100/7 returns 14.
